pic_n_ctrl: RTL and testbench
=============================

Name: pic_n_ctrl

Overview:
- Synchronous, parametrised successor to PIC_8259.
- Generalises the 8-input controller to NUM_IRQ request lines, with edge or level triggering, fully nested priority, and optional automatic priority rotation on EOI.
- Uses a simple register bus for masks, configuration and EOI, plus an INTA/vector handshake toward the CPU-side bus bridge.
- Sits between peripheral request lines and the CPU interrupt pin.

Parameters:
- NUM_IRQ, 8: number of request lines; legal range 2..32.
- ID_W, $clog2(NUM_IRQ): width of an interrupt id.
- DATA_W, 32: register bus width; must be >= NUM_IRQ and >= 16.

Ports:
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  synchronous reset, active-high.
- IR  in  NUM_IRQ  request lines, already synchronous to CLK.
- WE  in  1  register write strobe, one cycle.
- RE  in  1  register read strobe, one cycle.
- A  in  2  register address.
- DIN  in  DATA_W  write data.
- DOUT  out  DATA_W  read data, registered.
- INT  out  1  interrupt request to CPU, registered.
- INTA  in  1  acknowledge pulse, one cycle.
- VEC  out  8  vector for the acknowledged interrupt.
- VEC_VLD  out  1  VEC valid, one-cycle pulse.
- SPUR  out  1  qualifies VEC_VLD: acknowledge found nothing eligible.

Behaviour:
- Reset values: IMR all ones; CFG 0; IRR 0; ISR 0; ir_q 0; LOWPRI NUM_IRQ-1 (IR0 highest); state IDLE; DOUT 0; INT 0; VEC 0; VEC_VLD 0; SPUR 0.
- Registers:
  - Write A=0: IMR <= DIN[NUM_IRQ-1:0].
  - Write A=1: CFG. Bit0 LTIM (1 = level mode), bit1 AROT (rotate on EOI), bits[15:8] VBASE.
  - Write A=2: EOI. DIN[DATA_W-1]=0 is non-specific: clears the highest-priority set ISR bit. DIN[DATA_W-1]=1 is specific: clears ISR[DIN[ID_W-1:0]]. An out-of-range id is ignored.
  - Write A=3: ignored.
  - Read, zero-extended: A=0 IMR, A=1 CFG, A=2 ISR, A=3 IRR. DOUT updates the cycle after RE and holds until the next RE.
- Request capture:
  - Edge mode: IRR[i] sets when IR[i] & ~ir_q[i], where ir_q is IR registered one cycle.
  - Level mode: IRR[i] sets while IR[i] is high and clears when IR[i] is low.
  - IMR does not block capture.
- Priority:
  - Priority order starts at LOWPRI+1 and wraps modulo NUM_IRQ, ending with LOWPRI.
  - cand = highest-priority bit of IRR & ~IMR.
  - cand is eligible only if it is strictly higher priority than the highest set ISR bit; any candidate is eligible when ISR = 0.
  - INT is registered: the cycle after eligibility changes, INT = eligible candidate exists.
- FSM:
  - IDLE: INTA=1 -> RESOLVE.
  - RESOLVE: evaluates using the registered IRR/ISR/IMR.
    - Eligible id k: ISR[k] <= 1; in edge mode IRR[k] <= 0; latch VEC = VBASE + k, SPUR 0.
    - Nothing eligible: VEC = VBASE + NUM_IRQ - 1, SPUR 1, no ISR change.
    - Next state DRIVE.
  - DRIVE: VEC_VLD=1 for exactly one cycle -> IDLE.
  - INTA at cycle t gives VEC_VLD at t+2.
  - INTA outside IDLE is ignored.
- EOI and rotation:
  - EOI is accepted in any state.
  - If AROT=1, a non-specific or specific EOI that clears bit j sets LOWPRI <= j.
  - An EOI clearing nothing leaves LOWPRI unchanged.
- Simultaneous events:
  - Edge set and ack clear of the same IRR bit in one cycle: set wins, IRR stays 1.
  - EOI clear and ack set in one cycle: ISR_next = (ISR & ~eoi_clr) | ack_set.
  - An IMR or CFG write in the same cycle as RESOLVE takes effect next cycle; RESOLVE uses the old values.
  - Switching LTIM at runtime: IRR is recomputed from the new mode next cycle; ISR is unaffected.
- RST mid-handshake: aborts to IDLE, no VEC_VLD is produced, and all state returns to reset values.

Decomposition:
- Package pic_n_pkg:
  - Address constants A_IMR=0, A_CFG=1, A_ISR_EOI=2, A_IRR=3.
  - CFG bit positions LTIM=0, AROT=1, VBASE_LSB=8.
  - EOI_SPECIFIC_BIT=DATA_W-1.
  - State enum {IDLE, RESOLVE, DRIVE}.
- Sub-module pic_n_prio (combinational): inputs vector and LOWPRI; outputs found flag and highest-priority id, using rotate / find-first / un-rotate.
  - Instantiated twice: once for the candidate, once for the ISR top.

Test Plan:
- Reset, unmask all with IMR=0, CFG VBASE=0x20 edge mode; pulse IR3 -> IRR=0x08, INT=1.
  - Then INTA -> VEC=0x23 with VEC_VLD at t+2, ISR=0x08, IRR=0, INT=0.
- Nesting: ISR[3] set; raise IR5 -> INT stays 0. Raise IR1 -> INT=1, INTA -> VEC=0x21, ISR=0x0A.
  - Non-specific EOI -> ISR=0x08. Second EOI -> ISR=0, INT reflects IR5 pending.
- Rotation: AROT=1, service IR2 then EOI -> LOWPRI=2.
  - Pend IR2 and IR3 together -> INTA vectors IR3 first (0x23), then IR2 after EOI.
- Level mode: LTIM=1; hold IR7 high -> INT=1. Drop IR7 before INTA -> IRR=0, INT=0.
  - INTA -> VEC=0x27 with SPUR=1, ISR unchanged.
- Masking and corner cases:
  - IMR=0xFF, pulse IR0 -> IRR=0x01, INT=0. Unmask -> INT=1.
  - Edge set coincident with ack clear of the same bit -> IRR stays 1.
  - RST asserted in RESOLVE -> no VEC_VLD, all registers at reset values.

Source files
------------

// File: rtl/pic_n_pkg.sv
// pic_n_pkg: shared constants and helpers for the parametrised interrupt controller.
//   - register addresses, CFG bit positions, FSM state type
//   - wrap_idx: add-then-wrap helper for rotated priority indexing
package pic_n_pkg;

  localparam logic [1:0] A_IMR     = 2'd0;
  localparam logic [1:0] A_CFG     = 2'd1;
  localparam logic [1:0] A_ISR_EOI = 2'd2;
  localparam logic [1:0] A_IRR     = 2'd3;

  localparam int LTIM      = 0;
  localparam int AROT      = 1;
  localparam int VBASE_LSB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DRIVE   = 2'd2
  } state_e;

  // EOI write: the top data bit selects specific (1) vs non-specific (0).
  function automatic int eoi_specific_bit(input int data_w);
    return data_w - 1;
  endfunction

  // Reduce v into 0..n-1; callers only pass values below 2*n.
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/pic_n_prio.sv
// pic_n_prio: combinational rotating priority encoder.
//   vec    : request/in-service vector
//   lowpri : id of the lowest-priority line; lowpri+1 (mod NUM_IRQ) is highest
//   found  : at least one bit of vec is set
//   id     : highest-priority set bit of vec
module pic_n_prio
  import pic_n_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [ID_W-1:0]    lowpri,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  int                 base_s;
  logic [NUM_IRQ-1:0] rot_s;
  logic [ID_W-1:0]    pos_s;

  // Rotate so the highest-priority line lands at bit 0, find first, rotate back.
  always_comb begin
    base_s = wrap_idx(int'(lowpri) + 1, NUM_IRQ);
    rot_s  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      rot_s[i] = vec[ID_W'(wrap_idx(i + base_s, NUM_IRQ))];
    end
    found = 1'b0;
    pos_s = '0;
    // Scan downward so the lowest set position is the one left standing.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      found = found | rot_s[i];
      pos_s = rot_s[i] ? ID_W'(i) : pos_s;
    end
    id = ID_W'(wrap_idx(int'(pos_s) + base_s, NUM_IRQ));
  end

endmodule

// File: rtl/pic_n_ctrl.sv
// pic_n_ctrl: NUM_IRQ-line interrupt controller with edge/level capture, fully
// nested priority, optional rotation on EOI and an INTA/vector handshake.
//   CLK, RST        : clock, synchronous active-high reset
//   IR              : request lines (already synchronous)
//   WE, RE, A, DIN  : register bus write/read strobes, address, write data
//   DOUT            : registered read data, held until the next RE
//   INT             : registered interrupt request to the CPU
//   INTA            : acknowledge pulse; VEC/VEC_VLD/SPUR answer two cycles later
module pic_n_ctrl
  import pic_n_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ),
  parameter int DATA_W  = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] IR,
  input  logic               WE,
  input  logic               RE,
  input  logic [1:0]         A,
  input  logic [DATA_W-1:0]  DIN,
  output logic [DATA_W-1:0]  DOUT,
  output logic               INT,
  input  logic               INTA,
  output logic [7:0]         VEC,
  output logic               VEC_VLD,
  output logic               SPUR
);

  localparam int EOI_BIT = eoi_specific_bit(DATA_W);

  logic [NUM_IRQ-1:0] ir_q_r, irr_r, isr_r, imr_r;
  logic               ltim_r, arot_r;
  logic [7:0]         vbase_r;
  logic [ID_W-1:0]    lowpri_r;
  state_e             state_r, state_nxt_s;
  logic [DATA_W-1:0]  dout_r;
  logic               int_r, vec_vld_r, spur_r;
  logic [7:0]         vec_r;

  logic               cand_found_s, top_found_s, eligible_s, resolve_s, eoi_hit_s;
  logic [ID_W-1:0]    cand_id_s, top_id_s, eoi_id_s, din_id_s;
  logic [NUM_IRQ-1:0] edge_set_s, ack_set_s, ack_clr_s, eoi_clr_s, irr_nxt_s, isr_nxt_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic               din_unused_s;

  assign din_unused_s = ^DIN;
  assign din_id_s     = DIN[ID_W-1:0];

  // Position of id k in the current priority order (0 = highest).
  function automatic int rank_of(input logic [ID_W-1:0] k, input logic [ID_W-1:0] lp);
    int base;
    base = wrap_idx(int'(lp) + 1, NUM_IRQ);
    return (int'(k) >= base) ? (int'(k) - base) : (int'(k) + NUM_IRQ - base);
  endfunction

  pic_n_prio #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_cand (
    .vec(irr_r & ~imr_r), .lowpri(lowpri_r), .found(cand_found_s), .id(cand_id_s)
  );

  pic_n_prio #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_istop (
    .vec(isr_r), .lowpri(lowpri_r), .found(top_found_s), .id(top_id_s)
  );

  // Eligibility, acknowledge/EOI bit masks and next IRR/ISR values.
  always_comb begin
    eligible_s = cand_found_s &&
                 (!top_found_s || (rank_of(cand_id_s, lowpri_r) < rank_of(top_id_s, lowpri_r)));
    resolve_s  = (state_r == RESOLVE);
    edge_set_s = IR & ~ir_q_r;
    ack_set_s  = '0;
    ack_clr_s  = '0;
    if (resolve_s && eligible_s) begin
      ack_set_s[cand_id_s] = 1'b1;
      ack_clr_s[cand_id_s] = ~ltim_r;
    end else begin
      ack_set_s = '0;
      ack_clr_s = '0;
    end
    eoi_clr_s = '0;
    eoi_hit_s = 1'b0;
    eoi_id_s  = top_id_s;
    if (WE && (A == A_ISR_EOI)) begin
      if (DIN[EOI_BIT]) begin
        eoi_id_s = din_id_s;
        if (int'(din_id_s) < NUM_IRQ) begin
          eoi_hit_s = isr_r[din_id_s];
        end else begin
          eoi_hit_s = 1'b0;
        end
      end else begin
        eoi_id_s  = top_id_s;
        eoi_hit_s = top_found_s;
      end
      if (eoi_hit_s) begin
        eoi_clr_s[eoi_id_s] = 1'b1;
      end else begin
        eoi_clr_s = '0;
      end
    end else begin
      eoi_clr_s = '0;
    end
    // An edge arriving in the acknowledge cycle wins over the clear.
    irr_nxt_s = ltim_r ? IR : ((irr_r & ~ack_clr_s) | edge_set_s);
    isr_nxt_s = (isr_r & ~eoi_clr_s) | ack_set_s;
  end

  // Register read multiplexer, zero-extended to DATA_W.
  always_comb begin
    rd_data_s = '0;
    case (A)
      A_IMR:     rd_data_s[NUM_IRQ-1:0] = imr_r;
      A_CFG:     rd_data_s[15:0]        = {vbase_r, 6'b000000, arot_r, ltim_r};
      A_ISR_EOI: rd_data_s[NUM_IRQ-1:0] = isr_r;
      A_IRR:     rd_data_s[NUM_IRQ-1:0] = irr_r;
      default:   rd_data_s              = '0;
    endcase
  end

  // Request/in-service/mask/config/rotation state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_q_r   <= '0;
      irr_r    <= '0;
      isr_r    <= '0;
      imr_r    <= '1;
      ltim_r   <= 1'b0;
      arot_r   <= 1'b0;
      vbase_r  <= 8'h00;
      lowpri_r <= ID_W'(NUM_IRQ - 1);
    end else begin
      ir_q_r <= IR;
      irr_r  <= irr_nxt_s;
      isr_r  <= isr_nxt_s;
      if (WE && (A == A_IMR)) begin
        imr_r <= DIN[NUM_IRQ-1:0];
      end
      if (WE && (A == A_CFG)) begin
        ltim_r  <= DIN[LTIM];
        arot_r  <= DIN[AROT];
        vbase_r <= DIN[VBASE_LSB +: 8];
      end
      if (eoi_hit_s && arot_r) begin
        lowpri_r <= eoi_id_s;
      end
    end
  end

  // Acknowledge FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Acknowledge FSM next state; INTA outside IDLE is ignored.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = INTA ? RESOLVE : IDLE;
      RESOLVE: state_nxt_s = DRIVE;
      DRIVE:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Registered outputs: VEC_VLD is high exactly while the FSM sits in DRIVE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_r    <= '0;
      int_r     <= 1'b0;
      vec_r     <= 8'h00;
      vec_vld_r <= 1'b0;
      spur_r    <= 1'b0;
    end else begin
      int_r     <= eligible_s;
      vec_vld_r <= resolve_s;
      if (RE) begin
        dout_r <= rd_data_s;
      end
      if (resolve_s) begin
        vec_r  <= eligible_s ? (vbase_r + 8'(cand_id_s)) : (vbase_r + 8'(NUM_IRQ - 1));
        spur_r <= ~eligible_s;
      end
    end
  end

  assign DOUT    = dout_r;
  assign INT     = int_r;
  assign VEC     = vec_r;
  assign VEC_VLD = vec_vld_r;
  assign SPUR    = spur_r;

endmodule

// File: tb/tb_pic_n_ctrl.sv
// Scoreboard bench for pic_n_ctrl: reads and acknowledges push expected
// results into queues; a negedge monitor pops and compares them.
module tb_pic_n_ctrl;
  import pic_n_pkg::*;

  localparam int N  = 8;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST, WE, RE, INTA;
  logic [N-1:0]  IR;
  logic [1:0]    A;
  logic [DW-1:0] DIN, DOUT;
  logic          INT, VEC_VLD, SPUR;
  logic [7:0]    VEC;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic re_seen = 1'b0;

  logic [31:0] rq[$];
  string       rn[$];
  logic [8:0]  vq[$];
  int          vdue[$];
  string       vn[$];

  pic_n_ctrl #(.NUM_IRQ(N), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .IR(IR), .WE(WE), .RE(RE), .A(A), .DIN(DIN),
    .DOUT(DOUT), .INT(INT), .INTA(INTA), .VEC(VEC), .VEC_VLD(VEC_VLD), .SPUR(SPUR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    re_seen <= RE;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop expected read data / vectors whenever the DUT presents them.
  always @(negedge CLK) begin
    if (re_seen) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%0h expected none", DOUT);
      end else begin
        chk(rn.pop_front(), DOUT, rq.pop_front());
      end
    end
    if (VEC_VLD === 1'b1) begin
      if (vq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vec: got vec=0x%0h spur=%0b expected no VEC_VLD", VEC, SPUR);
      end else begin
        chk(vn.pop_front(), {23'd0, SPUR, VEC}, {23'd0, vq.pop_front()});
        chk("vec_latency", cyc, vdue.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    A = a; DIN = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    A = a; RE = 1'b1;
    rq.push_back(e);
    rn.push_back(nm);
    tick();
    RE = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    IR = m;
    tick();
    IR = '0;
    tick(2);
  endtask

  task automatic push_vec(input logic spur, input logic [7:0] v, input string nm);
    vq.push_back({spur, v});
    vdue.push_back(cyc + 2);
    vn.push_back(nm);
  endtask

  task automatic inta(input logic spur, input logic [7:0] v, input string nm);
    INTA = 1'b1;
    push_vec(spur, v, nm);
    tick();
    INTA = 1'b0;
    tick(3);
  endtask

  initial begin
    RST = 1'b1; WE = 1'b0; RE = 1'b0; INTA = 1'b0; IR = '0; A = 2'd0; DIN = '0;
    tick(3);
    RST = 1'b0;
    tick();
    // Reset state
    chk("rst_dout", DOUT, 32'h0);
    chk("rst_int", 32'(INT), 32'h0);
    chk("rst_vec", 32'(VEC), 32'h0);
    chk("rst_spur", 32'(SPUR), 32'h0);
    rd(A_IMR, 32'hFF, "rst_imr");
    rd(A_CFG, 32'h0, "rst_cfg");
    rd(A_ISR_EOI, 32'h0, "rst_isr");
    rd(A_IRR, 32'h0, "rst_irr");

    // Basic edge capture and acknowledge
    wr(A_IMR, 32'h0);
    wr(A_CFG, 32'h2000);
    rd(A_CFG, 32'h2000, "cfg_rb");
    pulse(8'h08);
    rd(A_IRR, 32'h08, "irr_ir3");
    chk("int_ir3", 32'(INT), 32'h1);
    inta(1'b0, 8'h23, "vec_ir3");
    rd(A_ISR_EOI, 32'h08, "isr_ir3");
    rd(A_IRR, 32'h0, "irr_after_ack");
    chk("int_after_ack", 32'(INT), 32'h0);

    // Nesting
    pulse(8'h20);
    chk("int_ir5_blocked", 32'(INT), 32'h0);
    rd(A_IRR, 32'h20, "irr_ir5");
    pulse(8'h02);
    chk("int_ir1_nest", 32'(INT), 32'h1);
    inta(1'b0, 8'h21, "vec_ir1");
    rd(A_ISR_EOI, 32'h0A, "isr_nested");
    wr(A_ISR_EOI, 32'h0);
    tick(2);
    rd(A_ISR_EOI, 32'h08, "isr_eoi1");
    chk("int_eoi1", 32'(INT), 32'h0);
    wr(A_ISR_EOI, 32'h0);
    tick(2);
    rd(A_ISR_EOI, 32'h0, "isr_eoi2");
    chk("int_ir5_pending", 32'(INT), 32'h1);
    inta(1'b0, 8'h25, "vec_ir5");
    wr(A_ISR_EOI, 32'h0);
    rd(A_IRR, 32'h0, "irr_clean");

    // Rotation
    wr(A_CFG, 32'h2002);
    pulse(8'h04);
    inta(1'b0, 8'h22, "vec_rot_ir2");
    wr(A_ISR_EOI, 32'h0);
    pulse(8'h0C);
    inta(1'b0, 8'h23, "vec_rot_ir3_first");
    rd(A_ISR_EOI, 32'h08, "isr_rot");
    rd(A_IRR, 32'h04, "irr_rot");
    chk("int_rot_ir2_lower", 32'(INT), 32'h0);
    wr(A_ISR_EOI, 32'h8000_0003);
    tick(2);
    chk("int_rot_after_spec_eoi", 32'(INT), 32'h1);
    inta(1'b0, 8'h22, "vec_rot_ir2_second");
    wr(A_ISR_EOI, 32'h0);
    rd(A_ISR_EOI, 32'h0, "isr_rot_done");

    // Level mode and spurious acknowledge
    wr(A_CFG, 32'h2001);
    IR = 8'h80;
    tick(3);
    chk("int_level", 32'(INT), 32'h1);
    rd(A_IRR, 32'h80, "irr_level");
    IR = '0;
    tick(2);
    rd(A_IRR, 32'h0, "irr_level_drop");
    chk("int_level_drop", 32'(INT), 32'h0);
    inta(1'b1, 8'h27, "vec_spurious");
    rd(A_ISR_EOI, 32'h0, "isr_spurious");

    // Masking
    wr(A_CFG, 32'h2000);
    wr(A_IMR, 32'hFF);
    pulse(8'h01);
    rd(A_IRR, 32'h01, "irr_masked");
    chk("int_masked", 32'(INT), 32'h0);
    wr(A_IMR, 32'h0);
    tick(2);
    chk("int_unmasked", 32'(INT), 32'h1);

    // Edge set coincident with acknowledge clear of the same bit
    INTA = 1'b1;
    push_vec(1'b0, 8'h20, "vec_coincident");
    tick();
    INTA = 1'b0;
    IR = 8'h01;
    tick();
    IR = '0;
    tick(3);
    rd(A_IRR, 32'h01, "irr_coincident");
    rd(A_ISR_EOI, 32'h01, "isr_coincident");
    chk("int_same_bit_in_service", 32'(INT), 32'h0);
    wr(A_ISR_EOI, 32'h0);
    tick(2);
    chk("int_after_eoi_ir0", 32'(INT), 32'h1);

    // Reset during RESOLVE
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick(3);
    chk("rst2_int", 32'(INT), 32'h0);
    chk("rst2_vec", 32'(VEC), 32'h0);
    chk("rst2_spur", 32'(SPUR), 32'h0);
    chk("rst2_dout", DOUT, 32'h0);
    rd(A_IMR, 32'hFF, "rst2_imr");
    rd(A_CFG, 32'h0, "rst2_cfg");
    rd(A_ISR_EOI, 32'h0, "rst2_isr");
    rd(A_IRR, 32'h0, "rst2_irr");

    tick(4);
    chk("vec_queue_drained", 32'(vq.size()), 32'h0);
    chk("read_queue_drained", 32'(rq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
